// File: rtl/mdu_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_if : E-stage handshake/bus between the pipeline and the MDU sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        use_d;
  logic        busy;
  logic        stall;
  logic [31:0] result;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output start, op, src_a, src_b, use_d,
    input  busy, stall, result, hi_q, lo_q
  );

  modport slave (
    input  start, op, src_a, src_b, use_d,
    output busy, stall, result, hi_q, lo_q
  );
endinterface
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_sequencer : multi-cycle HI/LO controller for the E-stage mult/div unit
// Optional macro MDU_DIVZERO_KEEP_EN: divide by zero is refused (no start).
// Rev 1.0
// ---------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  reset_n,
  mdu_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hi_n;
  logic [31:0] lo_n;

  logic        is_mul;
  logic        is_div;
  logic        div_zero;
  logic        div_block;
  logic        do_start;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] out_hi;
  logic [31:0] out_lo;

  assign is_mul   = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div   = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign div_zero = (bus.src_b == 32'd0);

`ifdef MDU_DIVZERO_KEEP_EN
  assign div_block = is_div && div_zero;
`else
  assign div_block = 1'b0;
`endif

  assign do_start = bus.start && (state == IDLE) && (is_mul || is_div) && !div_block;

  assign prod_s = $unsigned($signed({{32{bus.src_a[31]}}, bus.src_a}) *
                            $signed({{32{bus.src_b[31]}}, bus.src_b}));
  assign prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  assign abs_a = bus.src_a[31] ? (32'd0 - bus.src_a) : bus.src_a;
  assign abs_b = bus.src_b[31] ? (32'd0 - bus.src_b) : bus.src_b;
  assign mag_q = div_zero ? 32'd0 : (abs_a / abs_b);
  assign mag_r = div_zero ? 32'd0 : (abs_a % abs_b);
  assign quo_u = div_zero ? 32'd0 : (bus.src_a / bus.src_b);
  assign rem_u = div_zero ? 32'd0 : (bus.src_a % bus.src_b);

  always_comb begin
    out_hi = 32'd0;
    out_lo = 32'd0;
    case (bus.op)
      OP_MULT:  {out_hi, out_lo} = prod_s;
      OP_MULTU: {out_hi, out_lo} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          out_hi = bus.src_a;
          out_lo = 32'hFFFF_FFFF;
        end else begin
          out_hi = bus.src_a[31] ? (32'd0 - mag_r) : mag_r;
          out_lo = (bus.src_a[31] ^ bus.src_b[31]) ? (32'd0 - mag_q) : mag_q;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          out_hi = bus.src_a;
          out_lo = 32'hFFFF_FFFF;
        end else begin
          out_hi = rem_u;
          out_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (do_start) begin
            hi_n  <= out_hi;
            lo_n  <= out_lo;
            cnt   <= is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
            state <= RUN;
          end else if (bus.op == OP_MTHI) begin
            hi <= bus.src_a;
          end else if (bus.op == OP_MTLO) begin
            lo <= bus.src_a;
          end
        end
        default: begin
          if (cnt == 4'd1) begin
            hi    <= hi_n;
            lo    <= lo_n;
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.stall  = (bus.start || bus.busy) && bus.use_d;
  assign bus.result = (bus.op == OP_MFHI) ? hi :
                      (bus.op == OP_MFLO) ? lo : 32'd0;
  assign bus.hi_q   = hi;
  assign bus.lo_q   = lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdu_sequencer : scoreboard bench; stimulus pushes expected HI/LO and busy
// length, a monitor pops on each completion (busy falling). Rev 1.0
// ---------------------------------------------------------------------------
module tb_mdu_sequencer;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  mdu_if bus();

  mdu_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a busy falling edge is a completion; compare HI/LO and busy length.
  initial begin
    int  len;
    bit  prev;
    exp_t e;
    len  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        len  = 0;
      end else begin
        if (bus.busy) len++;
        else if (prev) begin
          if (sb.size() == 0) chk("unexpected_completion", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("hi_q", bus.hi_q, e.hi);
            chk("lo_q", bus.lo_q, e.lo);
            chk("busy_len", 64'(len), 64'(e.len));
          end
          len = 0;
        end
        prev = bus.busy;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int len,
                       input bit expect_run);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    if (expect_run) begin
      e.hi = ehi; e.lo = elo; e.len = len;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_hi;
    errors      = 0;
    checks      = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 4'd0;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.use_d   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi_q), 64'd0);
    chk("rst_lo", 64'(bus.lo_q), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MULT -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1);
    wait_idle();
    // DIV / DIVU -7 by 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
    wait_idle();
    issue(4'd4, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 10, 1'b1);
    wait_idle();
    // DIV 7 / -2, and the overflow corner
    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b1);
    wait_idle();
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b1);
    wait_idle();

    // MULTU with MFLO waiting in D; stray start mid-run must be ignored
    bus.use_d = 1'b1;
    bus.start = 1'b1;
    bus.op    = 4'd2;
    bus.src_a = 32'hFFFF_FFFF;
    bus.src_b = 32'hFFFF_FFFF;
    sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, len: 5});
    #1 chk("stall_t", 64'(bus.stall), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.start = (i == 2);
      bus.op    = (i == 2) ? 4'd1 : 4'd0;
      bus.src_a = 32'd7;
      bus.src_b = 32'd9;
      #1 chk("stall_run", 64'(bus.stall), 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd8;
    #1;
    chk("stall_done", 64'(bus.stall), 64'd0);
    chk("mflo", 64'(bus.result), 64'h0000_0001);
    bus.op    = 4'd0;
    bus.use_d = 1'b0;
    #1 chk("result_none", 64'(bus.result), 64'd0);

    // MTHI / MTLO / MFHI
    @(negedge clk);
    bus.op    = 4'd5;
    bus.src_a = 32'h1234_5678;
    @(negedge clk);
    bus.op    = 4'd6;
    bus.src_a = 32'hCAFE_F00D;
    #1;
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_hi", 64'(bus.hi_q), 64'h1234_5678);
    @(negedge clk);
    bus.op = 4'd7;
    #1 chk("mfhi", 64'(bus.result), 64'h1234_5678);
    bus.op = 4'd8;
    #1 chk("mflo_mtlo", 64'(bus.result), 64'hCAFE_F00D);
    bus.op = 4'd0;
    @(negedge clk);

    // MTHI arriving while busy is ignored
    issue(4'd2, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b1);
    hold_hi   = bus.hi_q;
    bus.op    = 4'd5;
    bus.src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mthi_in_run", 64'(bus.hi_q), 64'(hold_hi));
    bus.op = 4'd0;
    wait_idle();

    // DIVU by zero
`ifdef MDU_DIVZERO_KEEP_EN
    issue(4'd4, 32'd5, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    chk("dz_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("dz_hi", 64'(bus.hi_q), 64'd0);
    chk("dz_lo", 64'(bus.lo_q), 64'd42);
`else
    issue(4'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10, 1'b1);
    wait_idle();
    issue(4'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 10, 1'b1);
    wait_idle();
`endif

    // Reset mid-run: abort, no later write
    issue(4'd3, 32'd100, 32'd3, 32'd0, 32'd0, 0, 1'b0);
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hi", 64'(bus.hi_q), 64'd0);
    chk("arst_lo", 64'(bus.lo_q), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    chk("post_rst_hi", 64'(bus.hi_q), 64'd0);
    chk("post_rst_lo", 64'(bus.lo_q), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
